// File: rtl/lsu_mem_adapter.sv
// lsu_mem_adapter
//   Load/store adapter in front of a word-addressed data memory that has a
//   combinational read and a single-cycle full-word write. It accepts RV32I
//   LB/LH/LW/LBU/LHU/SB/SH/SW requests over valid/ready. Sub-word stores use
//   read-modify-write, and loads are sign- or zero-extended. Each request gets
//   exactly one registered response, with an error flag for illegal,
//   out-of-range or misaligned accesses.
//
//   Build option: define LSU_ALIGN_CHECK_EN to reject misaligned halfword and
//   word accesses. When it is not defined, the low offset bits are masked to
//   natural alignment instead.
//
//   Ports:
//     clk, rst_n              clock, asynchronous active-low reset
//     req_valid / req_ready   request handshake
//     req_we                  1 = store, 0 = load
//     req_funct3              RV32I access size/sign
//     req_addr                byte address
//     req_wdata               store data, right-aligned
//     resp_valid / resp_ready response handshake
//     resp_rdata              load result (0 for stores and errors)
//     resp_err                access rejected
//     mem_we                  memory write enable (one cycle per store)
//     mem_addr                word-aligned byte address to memory
//     mem_wdata               full word to write
//     mem_rdata               combinational read data for mem_addr
module lsu_mem_adapter #(
  parameter int MEM_WORDS  = 2048,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  localparam int unsigned AW1 = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] MEM_BYTES = AW1'(MEM_WORDS) << 2;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [2:0]            funct3_q, funct3_d;
  logic                  we_q, we_d;
  logic [31:0]           wdata_q, wdata_d;   // store data, then the merged word
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic                  req_illegal, req_oor, req_misal, req_err;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [31:0]           load_word, merged;

  // Request checks
  always_comb begin
    req_illegal = req_we ? (req_funct3 > 3'd2)
                         : (req_funct3 == 3'd3 || req_funct3 >= 3'd6);
    req_oor     = {1'b0, req_addr} >= MEM_BYTES;
`ifdef LSU_ALIGN_CHECK_EN
    req_misal   = ((req_funct3[1:0] == 2'd1) && req_addr[0]) ||
                  ((req_funct3[1:0] == 2'd2) && (req_addr[1:0] != 2'b00));
`else
    req_misal   = 1'b0;
`endif
    req_err     = req_illegal | req_oor | req_misal;
  end

  // Lane selection uses addr[1:0] for bytes and addr[1] for halfwords only;
  // this gives the alignment masking when the check is disabled.
  always_comb begin
    ld_byte = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    ld_half = mem_rdata[{addr_q[1], 4'b0000} +: 16];
    case (funct3_q)
      3'd0:    load_word = {{24{ld_byte[7]}}, ld_byte};
      3'd4:    load_word = {24'h0, ld_byte};
      3'd1:    load_word = {{16{ld_half[15]}}, ld_half};
      3'd5:    load_word = {16'h0, ld_half};
      default: load_word = mem_rdata;
    endcase

    merged = mem_rdata;
    if (funct3_q[1:0] == 2'd0)
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    else
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    funct3_d = funct3_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d   = req_addr;
          funct3_d = req_funct3;
          we_d     = req_we;
          wdata_d  = req_wdata;
          rdata_d  = '0;
          err_d    = 1'b0;
          if (req_err) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else if (req_we && req_funct3 == 3'd2) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        if (we_q) begin
          wdata_d = merged;
          state_d = WRITE;
        end else begin
          rdata_d = load_word;
          state_d = RESP;
        end
      end
      WRITE: state_d = RESP;
      RESP: begin
        if (resp_ready) begin
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      funct3_q <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      funct3_q <= funct3_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign mem_we     = (state_q == WRITE);
  assign mem_addr   = (state_q == READ || state_q == WRITE) ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign mem_wdata  = (state_q == WRITE) ? wdata_q : '0;

endmodule

// File: tb/tb_lsu_mem_adapter.sv
module tb_lsu_mem_adapter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem     [0:2047];
  logic [31:0] ref_mem [0:2047];
  logic        mem_inited = 1'b0;
  int          we_cnt = 0;
  logic [31:0] last_waddr = '0;
  logic [31:0] last_wdata = '0;

  lsu_mem_adapter #(.MEM_WORDS(2048), .ADDR_WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    if (i == 32'h40) return 32'h8899AABB;
    return (i * 32'h01030507) ^ 32'h5A5AC3C3;
  endfunction

  // Memory model: combinational read, one full word written per mem_we edge.
  assign mem_rdata = mem[mem_addr[12:2]];

  always @(posedge clk) begin
    if (!mem_inited) begin
      for (int i = 0; i < 2048; i++) mem[i] <= init_word(i);
      mem_inited <= 1'b1;
    end else if (mem_we) begin
      mem[mem_addr[12:2]] <= mem_wdata;
      we_cnt     <= we_cnt + 1;
      last_waddr <= mem_addr;
      last_wdata <= mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model written from the access rules.
  task automatic ref_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, output logic [31:0] rd, output logic err,
                            output int lat, output int nwr, output logic [31:0] wword);
    logic illegal, oor, misal;
    int unsigned off;
    logic [31:0] old, mask, v;
    rd = 0; wword = 0; nwr = 0; err = 0; lat = 1;
    illegal = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6);
    oor = addr >= 32'd8192;
`ifdef LSU_ALIGN_CHECK_EN
    misal = (f3[1:0] == 2'd1 && addr % 2 != 0) || (f3[1:0] == 2'd2 && addr % 4 != 0);
`else
    misal = 1'b0;
`endif
    if (illegal || oor || misal) begin
      err = 1;
      return;
    end
    old = ref_mem[addr / 4];
    off = addr % 4;
    case (f3[1:0])
      2'd0:    mask = 32'hFF;
      2'd1:    begin mask = 32'hFFFF; off = (off / 2) * 2; end
      default: begin mask = 32'hFFFFFFFF; off = 0; end
    endcase
    if (!we) begin
      v = (old >> (8 * off)) & mask;
      if (!f3[2] && mask == 32'hFF && v[7]) v = v | ~mask;
      if (!f3[2] && mask == 32'hFFFF && v[15]) v = v | ~mask;
      rd = v;
      lat = 2;
    end else begin
      wword = (old & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
      ref_mem[addr / 4] = wword;
      nwr = 1;
      lat = (f3[1:0] == 2'd2) ? 2 : 3;
    end
  endtask

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input int hold);
    logic [31:0] erd, ewword;
    logic eerr;
    int elat, ewr, lat, wc0;
    bit seen;
    ref_access(we, f3, addr, wd, erd, eerr, elat, ewr, ewword);
    resp_ready = (hold == 0);
    @(negedge clk);
    chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    wc0 = we_cnt;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1; seen = 0;
    while (!seen && lat <= 10) begin
      if (resp_valid) seen = 1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    chk("latency", lat, elat);
    if (!seen) return;
    chk("resp_rdata", resp_rdata, erd);
    chk("resp_err", {31'b0, resp_err}, {31'b0, eerr});
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("stall_valid", {31'b0, resp_valid}, 32'd1);
      chk("stall_rdata", resp_rdata, erd);
      chk("stall_ready", {31'b0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk("post_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("post_req_ready", {31'b0, req_ready}, 32'd1);
    chk("write_count", we_cnt - wc0, ewr);
    if (ewr != 0) begin
      chk("write_addr", last_waddr, {addr[31:2], 2'b00});
      chk("write_data", last_wdata, ewword);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wc0;
    int r;
    logic [31:0] a;
    for (int i = 0; i < 2048; i++) ref_mem[i] = init_word(i);

    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("init_resp_rdata", resp_rdata, 32'd0);
    chk("init_resp_err", {31'b0, resp_err}, 32'd0);
    chk("init_mem_addr", mem_addr, 32'd0);
    chk("init_mem_wdata", mem_wdata, 32'd0);

    do_req(1'b0, 3'd0, 32'h101, 32'h0, 0);          // LB
    do_req(1'b0, 3'd5, 32'h102, 32'h0, 0);          // LHU
    do_req(1'b0, 3'd1, 32'h102, 32'h0, 0);          // LH
    do_req(1'b0, 3'd4, 32'h100, 32'h0, 0);          // LBU
    do_req(1'b1, 3'd0, 32'h103, 32'h00000012, 0);   // SB
    do_req(1'b0, 3'd2, 32'h100, 32'h0, 0);          // LW
    do_req(1'b1, 3'd2, 32'h100, 32'h8899AABB, 0);   // SW restore
    do_req(1'b0, 3'd2, 32'h102, 32'h0, 0);          // misaligned LW
    do_req(1'b1, 3'd1, 32'h105, 32'h0000BEEF, 0);   // odd SH
    do_req(1'b0, 3'd2, 32'h2000, 32'h0, 0);         // first out-of-range
    do_req(1'b0, 3'd2, 32'h1FFC, 32'h0, 0);         // last word
    do_req(1'b0, 3'd3, 32'h100, 32'h0, 0);          // illegal load
    do_req(1'b1, 3'd4, 32'h100, 32'h0, 0);          // illegal store
    do_req(1'b0, 3'd2, 32'h100, 32'h0, 3);          // stalled response

    // Reset while the SH read-modify-write is in READ.
    @(negedge clk);
    resp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd1; req_addr = 32'h100; req_wdata = 32'h5555;
    wc0 = we_cnt;
    @(negedge clk);
    req_valid = 1'b0;
    chk("read_mem_addr", mem_addr, 32'h100);
    chk("read_mem_we", {31'b0, mem_we}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("mid_rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("mid_rst_mem_addr", mem_addr, 32'd0);
    chk("mid_rst_mem_wdata", mem_wdata, 32'd0);
    chk("mid_rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("mid_rst_resp_rdata", resp_rdata, 32'd0);
    chk("mid_rst_resp_err", {31'b0, resp_err}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_no_resp", {31'b0, resp_valid}, 32'd0);
    chk("rst_no_write", we_cnt - wc0, 32'd0);
    do_req(1'b0, 3'd2, 32'h100, 32'h0, 0);

    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(0, 9);
      if (r <= 6)      a = 32'h100 + $urandom_range(0, 31);
      else if (r == 7) a = 32'h1FF0 + $urandom_range(0, 31);
      else if (r == 8) a = $urandom;
      else             a = $urandom_range(0, 8191);
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
             $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
